// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt-side key scheduler.
//   NR / NK    : round count and key length in words (AES-256 only)
//   state_t    : scheduler FSM encoding
//   sbox()     : byte substitution, computed as GF(2^8) inverse + affine map
//   rcon()     : round constant for key-expansion step n (n = 0..6)
package aes_pkg;

  localparam int NR = 14;
  localparam int NK = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse is a^254 (a^(2+4+...+128)); 0 maps to 0 naturally.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(a, a);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // rcon values 01..40 never need modular reduction, so a shift suffices.
  function automatic logic [7:0] rcon(input logic [2:0] n);
    return 8'h01 << n;
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
//   a : input word
//   y : substituted word
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  always_comb begin
    y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  end

endmodule

// File: rtl/aes_dec_key_sched.sv
// Iterative AES-256 key scheduler serving round keys in decryption order.
//   clk, reset : clock, synchronous active-high reset
//   in         : 256-bit cipher key, sampled on an accepted start
//   start      : request expansion (accepted in IDLE or DONE)
//   round      : decryption round index; out follows one cycle later
//   busy       : expansion running
//   ready      : all 15 round keys valid
//   out        : encryption round key 14-round, or 0 when not ready / round>14
//   dbg_state  : FSM state for observation
//
// Handshake: start is a one-cycle request, accepted only when busy=0 (a start
// while busy is dropped, not queued). ready rises 13 cycles after acceptance
// and acts as the valid for the lookup path: out registers k[14-round] only
// on edges where ready was already high, and 0 otherwise.
module aes_dec_key_sched #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] in,
  input  logic         start,
  input  logic [3:0]   round,
  output logic         busy,
  output logic         ready,
  output logic [127:0] out,
  output logic [1:0]   dbg_state
);
  import aes_pkg::*;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state, state_next;
  logic         accept;
  logic [3:0]   idx;
  logic [127:0] key_mem [0:14];
  logic [127:0] prev2, prev1, new_key;
  logic [31:0]  sub_in, sub_out, t;
  logic [31:0]  n0, n1, n2, n3;

  // Next-state logic
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = EXPAND;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == EXPAND);
  assign ready     = (state == DONE);
  assign dbg_state = state;

  // One expansion step: k[idx] from k[idx-2] and k[idx-1].
  // Even steps rotate and add rcon; odd steps are plain SubWord.
  always_comb begin
    prev2   = key_mem[idx - 4'd2];
    prev1   = key_mem[idx - 4'd1];
    sub_in  = idx[0] ? prev1[31:0] : {prev1[23:0], prev1[31:24]};
    t       = sub_out ^ (idx[0] ? 32'h0 : {rcon(idx[3:1] - 3'd1), 24'h0});
    n0      = prev2[127:96] ^ t;
    n1      = prev2[95:64]  ^ n0;
    n2      = prev2[63:32]  ^ n1;
    n3      = prev2[31:0]   ^ n2;
    new_key = {n0, n1, n2, n3};
  end

  aes_sbox_word u_sbox (
    .a (sub_in),
    .y (sub_out)
  );

  // Control state, counter and registered lookup
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 4'd2;
      out   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        idx <= 4'd2;
      end else if (state == EXPAND && idx != LAST) begin
        idx <= idx + 4'd1;
      end
      out <= (ready && round <= LAST) ? key_mem[LAST - round] : '0;
    end
  end

  // Key store: no reset, contents are only meaningful while ready=1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept) begin
        key_mem[0] <= in[255:128];
        key_mem[1] <= in[127:0];
      end else if (state == EXPAND) begin
        key_mem[idx] <= new_key;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
module tb_aes_dec_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] in;
  logic         start;
  logic [3:0]   round;
  logic         busy;
  logic         ready;
  logic [127:0] out;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mon_exp;
  logic         look_en = 1'b0;
  logic         pend_q  = 1'b0;

  logic [7:0]   sbox_tb [256];
  logic [127:0] rk [15];
  bit           model_ready;

  localparam logic [255:0] KEY_A3 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  aes_dec_key_sched #(.NR(14)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .start     (start),
    .round     (round),
    .busy      (busy),
    .ready     (ready),
    .out       (out),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] tb_xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = tb_xtime(x);
    end
    return r;
  endfunction

  // S-box from its definition: brute-force multiplicative inverse, then the
  // bitwise affine map b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) ^ c_i.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tb[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
  endfunction

  // Textbook word-oriented AES-256 expansion into 60 words, then grouped.
  task automatic compute_model(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      temp = w[i-1];
      if (i % 8 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = tb_xtime(rc);
      end else if (i % 8 == 4) begin
        temp = sub_word(temp);
      end
      w[i] = w[i-8] ^ temp;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // out is valid one edge after a lookup is issued.
  always @(posedge clk) pend_q <= look_en;

  always @(negedge clk) begin
    if (pend_q) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL lookup_queue: got empty queue want an entry");
      end else begin
        mon_exp = exp_q.pop_front();
        check($sformatf("lookup_r%0d", round), out, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rand256(output logic [255:0] k);
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
  endtask

  task automatic lookup_exp(input logic [3:0] r, input logic [127:0] e);
    round   = r;
    look_en = 1'b1;
    exp_q.push_back(e);
    cyc();
    look_en = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] r);
    lookup_exp(r, (model_ready && r <= 4'd14) ? rk[4'd14 - r] : 128'h0);
  endtask

  // Start an expansion; optionally inject ignored start pulses at edges 3
  // and 13, or assert reset at edge abort_at (1..13) to abort.
  task automatic run_expand(input logic [255:0] key, input bit pulses, input int abort_at);
    logic [255:0] junk;
    in      = key;
    start   = 1'b1;
    look_en = 1'b0;
    cyc();
    start = 1'b0;
    rand256(junk);
    in = junk;
    model_ready = 0;
    check("busy_after_start", 128'(busy), 128'd1);
    check("ready_after_start", 128'(ready), 128'd0);
    for (int j = 1; j <= 13; j++) begin
      if (abort_at == j) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("busy_after_abort", 128'(busy), 128'd0);
        check("ready_after_abort", 128'(ready), 128'd0);
        check("out_after_abort", out, 128'h0);
        return;
      end
      if (pulses && (j == 3 || j == 13)) begin
        rand256(junk);
        in    = junk;
        start = 1'b1;
      end
      round   = 4'($urandom_range(0, 15));
      look_en = 1'b1;
      exp_q.push_back(128'h0);
      cyc();
      start   = 1'b0;
      look_en = 1'b0;
      if (j < 13) begin
        total++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          bad++;
          $display("FAIL expand_e%0d: got busy=%b ready=%b want busy=1 ready=0", j, busy, ready);
        end
      end else begin
        check("busy_done", 128'(busy), 128'd0);
        check("ready_done", 128'(ready), 128'd1);
      end
    end
    compute_model(key);
    model_ready = 1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] k;
    reset = 1'b1;
    start = 1'b0;
    in    = '0;
    round = '0;
    model_ready = 0;
    build_sbox();
    cyc();
    cyc();
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_ready", 128'(ready), 128'd0);
    check("reset_out", out, 128'h0);
    reset = 1'b0;

    // lookups before any key is valid
    lookup(4'd0);
    lookup(4'd14);

    // FIPS-197 A.3 key
    run_expand(KEY_A3, 0, 0);
    lookup_exp(4'd0,  128'hfe4890d1e6188d0b046df344706c631e);
    lookup_exp(4'd14, 128'h603deb1015ca71be2b73aef0857d7781);
    lookup_exp(4'd13, 128'h1f352c073b6108d72d9810a30914dff4);
    lookup_exp(4'd12, 128'h9ba354118e6925afa51a8b5f2067fcde);
    lookup_exp(4'd15, 128'h0);
    for (int r = 0; r < 15; r++) lookup(4'(r));

    // re-key from DONE with ignored start pulses at edges 3 and 13
    run_expand(KEY_A3, 1, 0);
    lookup_exp(4'd0,  128'hfe4890d1e6188d0b046df344706c631e);
    lookup_exp(4'd13, 128'h1f352c073b6108d72d9810a30914dff4);

    // re-key to all-zero key
    run_expand(256'h0, 0, 0);
    lookup_exp(4'd12, 128'h62636363626363636263636362636363);
    lookup_exp(4'd15, 128'h0);

    // abort mid-expansion, then a clean zero-key run
    run_expand(KEY_A3, 0, 5);
    lookup(4'd3);
    run_expand(256'h0, 0, 0);
    lookup_exp(4'd12, 128'h62636363626363636263636362636363);

    // random keys, random rounds
    repeat (4) begin
      rand256(k);
      run_expand(k, 0, 0);
      repeat (12) lookup(4'($urandom_range(0, 15)));
    end

    cyc();
    cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
